// File: rtl/fft_64p_reorder_if.sv
// Stream interface for fft_64p_reorder.
// The input side carries the FFT result in bit-reversed order.
// The output side carries the same samples in natural bin order, plus the frame error pulse.
interface fft_64p_reorder_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_sop;
    logic [DW-1:0] in_r;
    logic [DW-1:0] in_i;
    logic          out_valid;
    logic          out_sop;
    logic          out_eop;
    logic [DW-1:0] out_r;
    logic [DW-1:0] out_i;
    logic          err;

    // Environment side: the FFT drives the input stream and the consumer reads the output stream
    modport master (
        output in_valid, in_sop, in_r, in_i,
        input  out_valid, out_sop, out_eop, out_r, out_i, err
    );

    // Reorder buffer side
    modport slave (
        input  in_valid, in_sop, in_r, in_i,
        output out_valid, out_sop, out_eop, out_r, out_i, err
    );
endinterface

// File: rtl/fft_64p_reorder.sv
// fft_64p_reorder: bit-reversed to natural-order reorder buffer for the 64-point FFT.
// Two RAM banks work as a ping-pong pair: the writer fills one bank at bit-reversed
// addresses while the reader drains the other bank in natural order.
// Optional macro FFT_REORDER_ERR_EN adds the registered err pulse. The pulse fires on
// an in_sop that arrives mid-frame, and on a frame that is dropped because its bank is full.
module fft_64p_reorder #(
    parameter int N     = 64,
    parameter int LOG2N = 6,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fft_64p_reorder_if.slave bus
);
    typedef enum logic {WR_IDLE = 1'b0, WR_FILL = 1'b1} wr_state_t;
    typedef enum logic {RD_IDLE = 1'b0, RD_RUN  = 1'b1} rd_state_t;

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = a[LOG2N-1-b];
        end
        return r;
    endfunction

    logic [2*DW-1:0]  ram_r [0:2*N-1];

    wr_state_t        wr_state_r, wr_state_s;
    logic [LOG2N-1:0] wr_cnt_r, wr_cnt_s, wr_pos_s;
    logic             wr_bank_r, wr_bank_s, wr_en_s;
    logic [1:0]       bank_full_r, bank_set_s, bank_clr_s;

    rd_state_t        rd_state_r, rd_state_s;
    logic [LOG2N-1:0] rd_cnt_r, rd_cnt_s, rd_addr_s;
    logic             rd_bank_r, rd_bank_s, rd_en_s;

    logic             out_valid_r, out_sop_r, out_eop_r;
    logic [DW-1:0]    out_r_r, out_i_r;

    // Writer next state: frame start, fill, restart on mid-frame sop, hand-over when the bank is complete
    always_comb begin
        wr_state_s = wr_state_r;
        wr_cnt_s   = wr_cnt_r;
        wr_bank_s  = wr_bank_r;
        wr_en_s    = 1'b0;
        wr_pos_s   = wr_cnt_r;
        bank_set_s = 2'b00;
        case (wr_state_r)
            WR_IDLE: begin
                if (bus.in_valid && bus.in_sop && !bank_full_r[wr_bank_r]) begin
                    wr_en_s    = 1'b1;
                    wr_pos_s   = '0;
                    wr_cnt_s   = LOG2N'(1);
                    wr_state_s = WR_FILL;
                end else begin
                    // A sample without sop, or a frame whose bank is still draining, is ignored
                    wr_state_s = WR_IDLE;
                end
            end
            WR_FILL: begin
                if (bus.in_valid && bus.in_sop) begin
                    // Discard the partial frame and restart it in the same bank
                    wr_en_s    = 1'b1;
                    wr_pos_s   = '0;
                    wr_cnt_s   = LOG2N'(1);
                    wr_state_s = WR_FILL;
                end else if (bus.in_valid) begin
                    wr_en_s  = 1'b1;
                    wr_pos_s = wr_cnt_r;
                    if (wr_cnt_r == CNT_LAST) begin
                        bank_set_s = wr_bank_r ? 2'b10 : 2'b01;
                        wr_bank_s  = ~wr_bank_r;
                        wr_cnt_s   = '0;
                        wr_state_s = WR_IDLE;
                    end else begin
                        wr_cnt_s = wr_cnt_r + LOG2N'(1);
                    end
                end else begin
                    wr_state_s = WR_FILL;
                end
            end
            default: begin
                wr_state_s = WR_IDLE;
                wr_cnt_s   = '0;
            end
        endcase
    end

    // Reader next state. An idle reader issues address 0 in the same cycle that it sees a full bank,
    // which makes bin 0 appear two cycles after the last write.
    always_comb begin
        rd_state_s = rd_state_r;
        rd_cnt_s   = rd_cnt_r;
        rd_bank_s  = rd_bank_r;
        rd_en_s    = 1'b0;
        rd_addr_s  = rd_cnt_r;
        bank_clr_s = 2'b00;
        case (rd_state_r)
            RD_IDLE: begin
                if (bank_full_r[rd_bank_r]) begin
                    rd_en_s    = 1'b1;
                    rd_addr_s  = '0;
                    rd_cnt_s   = LOG2N'(1);
                    rd_state_s = RD_RUN;
                end else begin
                    rd_state_s = RD_IDLE;
                end
            end
            RD_RUN: begin
                rd_en_s   = 1'b1;
                rd_addr_s = rd_cnt_r;
                if (rd_cnt_r == CNT_LAST) begin
                    bank_clr_s = rd_bank_r ? 2'b10 : 2'b01;
                    rd_bank_s  = ~rd_bank_r;
                    rd_cnt_s   = '0;
                    rd_state_s = bank_full_r[~rd_bank_r] ? RD_RUN : RD_IDLE;
                end else begin
                    rd_cnt_s = rd_cnt_r + LOG2N'(1);
                end
            end
            default: begin
                rd_state_s = RD_IDLE;
                rd_cnt_s   = '0;
            end
        endcase
    end

    // Writer and reader state registers, and the bank-full flags (the writer sets one bank while the reader clears the other)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_state_r  <= WR_IDLE;
            wr_cnt_r    <= '0;
            wr_bank_r   <= 1'b0;
            rd_state_r  <= RD_IDLE;
            rd_cnt_r    <= '0;
            rd_bank_r   <= 1'b0;
            bank_full_r <= 2'b00;
        end else begin
            wr_state_r  <= wr_state_s;
            wr_cnt_r    <= wr_cnt_s;
            wr_bank_r   <= wr_bank_s;
            rd_state_r  <= rd_state_s;
            rd_cnt_r    <= rd_cnt_s;
            rd_bank_r   <= rd_bank_s;
            bank_full_r <= (bank_full_r & ~bank_clr_s) | bank_set_s;
        end
    end

    // Sample RAM write at the bit-reversed position (contents are never cleared)
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_s) begin
            ram_r[{wr_bank_r, bitrev(wr_pos_s)}] <= {bus.in_r, bus.in_i};
        end
    end

    // Registered RAM read and frame markers; the output data holds its last value between frames
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_r_r     <= '0;
            out_i_r     <= '0;
        end else begin
            out_valid_r <= rd_en_s;
            out_sop_r   <= rd_en_s && (rd_addr_s == '0);
            out_eop_r   <= rd_en_s && (rd_addr_s == CNT_LAST);
            if (rd_en_s) begin
                {out_r_r, out_i_r} <= ram_r[{rd_bank_r, rd_addr_s}];
            end
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_sop   = out_sop_r;
    assign bus.out_eop   = out_eop_r;
    assign bus.out_r     = out_r_r;
    assign bus.out_i     = out_i_r;

`ifdef FFT_REORDER_ERR_EN
    logic err_evt_s;
    logic err_r;

    assign err_evt_s = bus.in_valid && bus.in_sop &&
                       ((wr_state_r == WR_FILL) || bank_full_r[wr_bank_r]);

    // One-cycle error pulse, registered one cycle after a mid-frame sop or a dropped frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_evt_s;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

endmodule
